// File: rtl/guess_evaluator_pkg.sv
// Shared definitions for the whack-a-mole round controller: FSM states,
// score ceiling and mole position width.
package guess_evaluator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_MOLE = 3'd2,
        ST_ARMED     = 3'd3,
        ST_HOLD      = 3'd4,
        ST_OVER      = 3'd5
    } state_e;

    localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;
    localparam int          MOLE_W        = 3;
    localparam int          CNT_W         = 28;

endpackage

// File: rtl/guess_evaluator_bcd_counter.sv
// 4-digit packed BCD counter: synchronous clear, enable-driven increment
// that saturates at 9999.
module bcd_counter
    import guess_evaluator_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [15:0] o_count
);

    logic [15:0] r_count;
    logic [15:0] w_count_inc;
    logic        w_carry;

    // Ripple a decimal carry through the four nibbles.
    always_comb begin
        w_count_inc = r_count;
        w_carry     = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (w_carry) begin
                if (r_count[4*d +: 4] == 4'd9) begin
                    w_count_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
                    w_carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 16'h0000;
        end else if (i_clr) begin
            r_count <= 16'h0000;
        end else if (i_inc && (r_count != SCORE_MAX_BCD)) begin
            r_count <= w_count_inc;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/guess_evaluator.sv
// Whack-a-mole round controller and scorer. Define ROUND_TIMEOUT_EN to make
// an unanswered round count as a miss after ROUND_TICKS armed cycles.
module guess_evaluator
    import guess_evaluator_pkg::*;
#(
    parameter int unsigned ROUND_TICKS = 200_000_000,
    parameter int unsigned HOLD_TICKS  = 100_000_000,
    parameter int unsigned MAX_MISSES  = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_restart_game,
    input  logic              i_guess_valid,
    input  logic [MOLE_W-1:0] i_user_guess,
    input  logic              i_mole_valid,
    input  logic [MOLE_W-1:0] i_mole_position,
    output logic              o_mole_req,
    output logic [MOLE_W-1:0] o_mole_position,
    output logic              o_user_right,
    output logic              o_user_wrong,
    output logic              o_game_over,
    output logic [15:0]       o_score,
    output logic [1:0]        o_misses,
    output logic [2:0]        o_dbg_state
);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TICKS - 1);
    localparam logic [1:0]       MISS_LIMIT = 2'(MAX_MISSES);

    state_e            r_state;
    state_e            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mole_req;
    logic              r_user_right;
    logic              r_user_wrong;
    logic              r_game_over;
    logic [1:0]        r_misses;
    logic [MOLE_W-1:0] r_mole_position;

    logic w_guess_taken;
    logic w_correct;
    logic w_timeout;
    logic w_cnt_run;
    logic w_hold_done;
    logic w_right_ev;
    logic w_wrong_ev;

    assign w_guess_taken = (r_state == ST_ARMED) && i_guess_valid;
    assign w_correct     = (i_user_guess == r_mole_position);
    assign w_hold_done   = (r_state == ST_HOLD) && (r_cnt == HOLD_LAST);

`ifdef ROUND_TIMEOUT_EN
    localparam logic [CNT_W-1:0] ROUND_LAST = CNT_W'(ROUND_TICKS - 1);
    // A guess arriving on the timeout edge takes precedence over the timeout.
    assign w_timeout = (r_state == ST_ARMED) && !i_guess_valid && (r_cnt == ROUND_LAST);
    assign w_cnt_run = (r_state == ST_ARMED) || (r_state == ST_HOLD);
`else
    assign w_timeout = 1'b0;
    assign w_cnt_run = (r_state == ST_HOLD);
`endif

    assign w_right_ev = !i_restart_game && w_guess_taken && w_correct;
    assign w_wrong_ev = !i_restart_game && ((w_guess_taken && !w_correct) || w_timeout);

    always_comb begin
        w_state_next = r_state;
        if (i_restart_game) begin
            w_state_next = ST_REQ;
        end else begin
            case (r_state)
                ST_IDLE:      w_state_next = ST_IDLE;
                ST_REQ:       w_state_next = ST_WAIT_MOLE;
                ST_WAIT_MOLE: if (i_mole_valid) w_state_next = ST_ARMED;
                ST_ARMED:     if (w_guess_taken || w_timeout) w_state_next = ST_HOLD;
                ST_HOLD: begin
                    if (w_hold_done) begin
                        w_state_next = (r_misses == MISS_LIMIT) ? ST_OVER : ST_REQ;
                    end
                end
                ST_OVER:      w_state_next = ST_OVER;
                default:      w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_mole_req      <= 1'b0;
            r_user_right    <= 1'b0;
            r_user_wrong    <= 1'b0;
            r_game_over     <= 1'b0;
            r_misses        <= 2'd0;
            r_mole_position <= '0;
        end else begin
            r_state      <= w_state_next;
            r_mole_req   <= (w_state_next == ST_REQ);
            r_game_over  <= (w_state_next == ST_OVER);
            r_user_right <= w_right_ev;
            r_user_wrong <= w_wrong_ev;

            // Counter restarts on every state entry, including a restart re-entering REQ.
            if (i_restart_game || (w_state_next != r_state)) begin
                r_cnt <= '0;
            end else if (w_cnt_run) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (i_restart_game) begin
                r_misses        <= 2'd0;
                r_mole_position <= '0;
            end else begin
                if (w_wrong_ev) begin
                    r_misses <= r_misses + 2'd1;
                end
                if ((r_state == ST_WAIT_MOLE) && i_mole_valid) begin
                    r_mole_position <= i_mole_position;
                end
            end
        end
    end

    bcd_counter u_score (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_restart_game),
        .i_inc   (w_right_ev),
        .o_count (o_score)
    );

    assign o_mole_req      = r_mole_req;
    assign o_mole_position = r_mole_position;
    assign o_user_right    = r_user_right;
    assign o_user_wrong    = r_user_wrong;
    assign o_game_over     = r_game_over;
    assign o_misses        = r_misses;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_guess_evaluator.sv
// Self-checking bench for guess_evaluator: scripted rounds drive a
// transaction-level score/miss model checked against the DUT every cycle.
module tb_guess_evaluator;

  localparam int ROUND_T = 8;
  localparam int HOLD_T  = 2;
  localparam int MAX_M   = 3;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_restart_game;
  logic        i_guess_valid;
  logic [2:0]  i_user_guess;
  logic        i_mole_valid;
  logic [2:0]  i_mole_position;
  logic        o_mole_req;
  logic [2:0]  o_mole_position;
  logic        o_user_right;
  logic        o_user_wrong;
  logic        o_game_over;
  logic [15:0] o_score;
  logic [1:0]  o_misses;
  logic [2:0]  o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  // Model: score as a plain integer, miss count, latched mole, level and strobes.
  int         m_score  = 0;
  int         m_misses = 0;
  logic [2:0] m_mole   = 3'd0;
  bit         m_over   = 0;
  bit         m_req    = 0;
  bit         m_right  = 0;
  bit         m_wrong  = 0;

  guess_evaluator #(
    .ROUND_TICKS (ROUND_T),
    .HOLD_TICKS  (HOLD_T),
    .MAX_MISSES  (MAX_M)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_restart_game  (i_restart_game),
    .i_guess_valid   (i_guess_valid),
    .i_user_guess    (i_user_guess),
    .i_mole_valid    (i_mole_valid),
    .i_mole_position (i_mole_position),
    .o_mole_req      (o_mole_req),
    .o_mole_position (o_mole_position),
    .o_user_right    (o_user_right),
    .o_user_wrong    (o_user_wrong),
    .o_game_over     (o_game_over),
    .o_score         (o_score),
    .o_misses        (o_misses),
    .o_dbg_state     (o_dbg_state)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, every cycle away from the active edge
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("score",     32'(o_score),         32'(to_bcd(m_score)));
      chk("misses",    32'(o_misses),        32'(m_misses));
      chk("mole_pos",  32'(o_mole_position), 32'(m_mole));
      chk("game_over", 32'(o_game_over),     32'(m_over));
      chk("mole_req",  32'(o_mole_req),      32'(m_req));
      chk("right",     32'(o_user_right),    32'(m_right));
      chk("wrong",     32'(o_user_wrong),    32'(m_wrong));
    end
  end

  // driver tasks: each tick lands 1 time unit after a rising edge
  task automatic tick();
    @(posedge i_clk);
    #1;
    i_restart_game = 1'b0;
    i_guess_valid  = 1'b0;
    i_mole_valid   = 1'b0;
    m_req   = 0;
    m_right = 0;
    m_wrong = 0;
  endtask

  task automatic verdict(input bit hit);
    if (hit) begin
      m_right = 1;
      if (m_score < 9999) m_score++;
    end else begin
      m_wrong = 1;
      m_misses++;
    end
  endtask

  // first HOLD cycle is current; HOLD spans HOLD_T cycles in total
  task automatic finish_hold();
    repeat (HOLD_T - 1) tick();
    tick();
    if (m_misses == MAX_M) m_over = 1;
    else m_req = 1;
  endtask

  task automatic restart();
    i_restart_game = 1'b1;
    tick();
    m_score  = 0;
    m_misses = 0;
    m_mole   = 3'd0;
    m_over   = 0;
    m_req    = 1;
  endtask

  // precondition: current cycle is the request cycle
  task automatic play_round(input logic [2:0] mole, input logic [2:0] guess,
                            input int delay, input bit noise);
    tick();
    if (noise) begin
      i_guess_valid = 1'b1;
      i_user_guess  = mole;
      tick();
    end
    i_mole_valid    = 1'b1;
    i_mole_position = mole;
    tick();
    m_mole = mole;
    repeat (delay) tick();
    i_guess_valid = 1'b1;
    i_user_guess  = guess;
    tick();
    verdict(guess == mole);
    if (noise) begin
      i_guess_valid   = 1'b1;
      i_user_guess    = mole;
      i_mole_valid    = 1'b1;
      i_mole_position = ~mole;
    end
    finish_hold();
  endtask

  task automatic arm_round(input logic [2:0] mole);
    tick();
    i_mole_valid    = 1'b1;
    i_mole_position = mole;
    tick();
    m_mole = mole;
  endtask

  initial begin
    i_rst_n         = 1'b1;
    i_restart_game  = 1'b0;
    i_guess_valid   = 1'b0;
    i_user_guess    = 3'd0;
    i_mole_valid    = 1'b0;
    i_mole_position = 3'd0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_score",  32'(o_score),      32'h0);
    chk("rst_req",    32'(o_mole_req),   32'h0);
    chk("rst_over",   32'(o_game_over),  32'h0);
    chk_en = 1;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    tick();
    tick();

    // restart -> one-cycle request
    restart();
    chk("restart_req", 32'(o_mole_req), 32'h1);

    // correct guess 5 == 5
    play_round(3'd5, 3'd5, 1, 1);
    chk("first_win_score", 32'(o_score), 32'h0001);
    for (int i = 0; i < 8; i++) play_round(3'(i), 3'(i), i % 3, 1);
    chk("nine_wins", 32'(o_score), 32'h0009);
    play_round(3'd2, 3'd2, 0, 1);
    chk("bcd_carry", 32'(o_score), 32'h0010);

    // three misses end the game
    play_round(3'd1, 3'd4, 2, 1);
    play_round(3'd7, 3'd0, 0, 1);
    play_round(3'd3, 3'd6, 1, 1);
    chk("over_misses", 32'(o_misses), 32'd3);
    chk("over_level",  32'(o_game_over), 32'h1);
    for (int i = 0; i < 4; i++) begin
      i_guess_valid   = 1'b1;
      i_user_guess    = 3'(i);
      i_mole_valid    = 1'b1;
      i_mole_position = 3'(i + 1);
      tick();
    end
    restart();

`ifdef ROUND_TIMEOUT_EN
    // timeout with no guess: wrong strobe 8 cycles after ARMED entry
    arm_round(3'd4);
    repeat (ROUND_T - 1) tick();
    tick();
    verdict(0);
    chk("timeout_wrong", 32'(o_user_wrong), 32'h1);
    finish_hold();
    // correct guess on the timeout edge
    arm_round(3'd6);
    repeat (ROUND_T - 1) tick();
    i_guess_valid = 1'b1;
    i_user_guess  = 3'd6;
    tick();
    verdict(1);
    finish_hold();
    // wrong guess on the timeout edge
    arm_round(3'd1);
    repeat (ROUND_T - 1) tick();
    i_guess_valid = 1'b1;
    i_user_guess  = 3'd2;
    tick();
    verdict(0);
    finish_hold();
    chk("timeout_misses", 32'(o_misses), 32'd2);
    restart();
`endif

    // restart in ARMED with a simultaneous guess
    play_round(3'd3, 3'd3, 0, 0);
    play_round(3'd0, 3'd5, 0, 0);
    arm_round(3'd7);
    i_guess_valid  = 1'b1;
    i_user_guess   = 3'd7;
    i_restart_game = 1'b1;
    tick();
    m_score  = 0;
    m_misses = 0;
    m_mole   = 3'd0;
    m_req    = 1;

    // async reset during HOLD
    arm_round(3'd6);
    i_guess_valid = 1'b1;
    i_user_guess  = 3'd6;
    tick();
    verdict(1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_hold_right", 32'(o_user_right), 32'h0);
    chk("rst_hold_score", 32'(o_score),      32'h0);
    chk("rst_hold_mole",  32'(o_mole_position), 32'h0);
    m_score = 0;
    m_mole  = 3'd0;
    m_right = 0;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    tick();

    // saturation at 9999
    restart();
    for (int i = 0; i < 9999; i++) play_round(3'(i), 3'(i), 0, 0);
    chk("score_9999", 32'(o_score), 32'h9999);
    arm_round(3'd5);
    i_guess_valid = 1'b1;
    i_user_guess  = 3'd5;
    tick();
    verdict(1);
    chk("sat_right", 32'(o_user_right), 32'h1);
    chk("sat_score", 32'(o_score),      32'h9999);
    finish_hold();
    tick();

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
